// File: rtl/accum_core.sv
`default_nettype none
// ============================================================================
// Module      : accum_core
// Description : Parametrised multi-cycle accumulator processor core.
//               Unpipelined FETCH -> DECODE -> EXEC (-> MEM) sequencer with an
//               accumulator, a small register file, a carry flag and a
//               terminal HALT state. Instruction and data memory share one
//               external synchronous-read port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DW        data, address and instruction width (>= 6)
//   NREG      register-file entries, power of 2, 2 <= NREG <= 2^(DW-3)
//   RESET_PC  program counter value loaded by reset
// Ports:
//   clk        in   1   clock, all state updates on posedge
//   rst        in   1   synchronous active-high reset
//   run        in   1   fetch enable, sampled only in FETCH
//   mem_addr   out  DW  memory address (pc, or acc for LW/SW in EXEC)
//   mem_wdata  out  DW  store data (R[r] during SW EXEC, else 0)
//   mem_we     out  1   write strobe, high only in SW EXEC and never in reset
//   mem_rdata  in   DW  read data, valid the cycle after mem_addr
//   acc_out    out  DW  accumulator
//   pc_out     out  DW  program counter
//   carry      out  1   carry / borrow flag
//   halted     out  1   core sits in HALT
//   retire     out  1   pulse in the final cycle of each instruction
// ============================================================================
module accum_core #(
    parameter int DW       = 8,
    parameter int NREG     = 4,
    parameter int RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] acc_out,
    output logic [DW-1:0] pc_out,
    output logic          carry,
    output logic          halted,
    output logic          retire
);

    localparam int            c_RW       = $clog2(NREG);
    localparam int            c_OW       = DW - 3;
    localparam logic [DW-1:0] c_RESET_PC = DW'(RESET_PC);
    localparam logic [DW-1:0] c_ONE      = DW'(1);

    // Sequencer states
    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_HALT   = 3'd4;

    // Opcodes
    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_LI  = 3'd3;
    localparam logic [2:0] c_OP_MOV = 3'd4;
    localparam logic [2:0] c_OP_LW  = 3'd5;
    localparam logic [2:0] c_OP_SW  = 3'd6;
    localparam logic [2:0] c_OP_BRZ = 3'd7;

    logic [2:0]    r_state;
    logic [DW-1:0] r_pc;
    logic [DW-1:0] r_acc;
    logic          r_carry;
    logic [DW-1:0] r_instr;
    logic [DW-1:0] r_regs [NREG];

    logic [2:0]      w_op;
    logic [c_OW-1:0] w_operand;
    logic [c_RW-1:0] w_ridx;
    logic [DW-1:0]   w_rval;
    logic [DW-1:0]   w_li_val;
    logic [DW:0]     w_sum;
    logic [DW:0]     w_diff;
    logic            w_is_halt;

    // Instruction fields come from the latched instruction, so they are
    // stable throughout EXEC and MEM.
    assign w_op      = r_instr[DW-1:DW-3];
    assign w_operand = r_instr[DW-4:0];
    assign w_ridx    = w_operand[c_RW-1:0];
    assign w_rval    = r_regs[w_ridx];
    assign w_li_val  = {{3{w_operand[c_OW-1]}}, w_operand};

    // One extra bit on both adders: bit DW of the sum is the carry-out and
    // bit DW of the difference is the unsigned borrow (acc < R[r]).
    assign w_sum     = {1'b0, r_acc} + {1'b0, w_rval};
    assign w_diff    = {1'b0, r_acc} - {1'b0, w_rval};

    // BRZ with an all-ones operand is the HALT encoding; it halts
    // unconditionally and never branches.
    assign w_is_halt = (w_op == c_OP_BRZ) && (&w_operand);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_FETCH;
            r_pc    <= c_RESET_PC;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_instr <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_FETCH: begin
                    if (run) begin
                        r_state <= c_ST_DECODE;
                    end
                end
                c_ST_DECODE: begin
                    r_instr <= mem_rdata;
                    r_pc    <= r_pc + c_ONE;
                    r_state <= c_ST_EXEC;
                end
                c_ST_EXEC: begin
                    r_state <= c_ST_FETCH;
                    case (w_op)
                        c_OP_ADD: begin
                            r_acc   <= w_sum[DW-1:0];
                            r_carry <= w_sum[DW];
                        end
                        c_OP_SUB: begin
                            r_acc   <= w_diff[DW-1:0];
                            r_carry <= w_diff[DW];
                        end
                        c_OP_AND: r_acc <= r_acc & w_rval;
                        c_OP_LI:  r_acc <= w_li_val;
                        c_OP_MOV: r_regs[w_ridx] <= r_acc;
                        c_OP_LW:  r_state <= c_ST_MEM;
                        c_OP_SW:  ; // store is driven combinationally below
                        c_OP_BRZ: begin
                            if (w_is_halt) begin
                                r_state <= c_ST_HALT;
                            end else if (r_acc == '0) begin
                                // Overrides the pc+1 done in DECODE.
                                r_pc <= w_rval;
                            end
                        end
                        default: ;
                    endcase
                end
                c_ST_MEM: begin
                    r_regs[w_ridx] <= mem_rdata;
                    r_state        <= c_ST_FETCH;
                end
                c_ST_HALT: begin
                    r_state <= c_ST_HALT;
                end
                default: begin
                    r_state <= c_ST_FETCH;
                end
            endcase
        end
    end

    // Memory port and retire strobe are decoded from the state register.
    // mem_we is additionally masked by rst so a reset landing on a SW EXEC
    // cycle suppresses the store at that same edge.
    always_comb begin
        mem_addr  = r_pc;
        mem_wdata = '0;
        mem_we    = 1'b0;
        retire    = 1'b0;
        if (r_state == c_ST_EXEC) begin
            retire = (w_op != c_OP_LW);
            if (w_op == c_OP_LW) begin
                mem_addr = r_acc;
            end
            if (w_op == c_OP_SW) begin
                mem_addr  = r_acc;
                mem_wdata = w_rval;
                mem_we    = ~rst;
            end
        end
        if (r_state == c_ST_MEM) begin
            retire = 1'b1;
        end
    end

    assign acc_out = r_acc;
    assign pc_out  = r_pc;
    assign carry   = r_carry;
    assign halted  = (r_state == c_ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_accum_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_core
// Description : Self-checking bench for accum_core (DW=8, NREG=4,
//               RESET_PC=0). Table-driven ALU vectors through a scoreboard
//               queue plus hand-written programs for timing, memory,
//               branch, reset and stall corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic [7:0] acc_out;
    logic [7:0] pc_out;
    logic       carry;
    logic       halted;
    logic       retire;

    always #5 clk = ~clk;

    accum_core #(.DW(8), .NREG(4), .RESET_PC(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .acc_out   (acc_out),
        .pc_out    (pc_out),
        .carry     (carry),
        .halted    (halted),
        .retire    (retire)
    );

    // Synchronous-read memory model with a bench-side load port.
    logic [7:0] mem [256];
    logic       tb_clr = 1'b0;
    logic       tb_we  = 1'b0;
    logic [7:0] tb_addr = 8'h00;
    logic [7:0] tb_data = 8'h00;

    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] prog [32];
    int         plen;

    // Observations gathered by run_prog
    int         hcyc;
    int         nret;
    int         we_cnt;
    logic [7:0] we_addr;
    logic [7:0] we_data;
    logic [7:0] pc_at_stall;
    int         ret_cyc[$];
    logic [7:0] pc_after[$];

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_acc;
        logic       exp_c;
    } vec_t;
    typedef struct {
        logic [7:0] acc;
        logic       c;
    } exp_t;

    vec_t vecs [10];
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pw(input int a, input logic [7:0] d);
        prog[a] = d;
        if (a + 1 > plen) plen = a + 1;
    endtask

    task automatic begin_test();
        rst  = 1'b1;
        run  = 1'b1;
        plen = 0;
    endtask

    task automatic load_prog();
        @(negedge clk);
        tb_clr = 1'b1;
        @(negedge clk);
        tb_clr = 1'b0;
        for (int i = 0; i < plen; i++) begin
            tb_we   = 1'b1;
            tb_addr = 8'(i);
            tb_data = prog[i];
            @(negedge clk);
        end
        tb_we = 1'b0;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tb_we   = 1'b1;
        tb_addr = a;
        tb_data = d;
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    // Leaves the bench at the negedge of cycle 0 after reset release.
    task automatic reset_core(input bit chk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (chk) begin
            check("reset_pc", pc_out, 8'h00);
            check("reset_acc", acc_out, 8'h00);
            check("reset_carry", carry, 1'b0);
            check("reset_halted", halted, 1'b0);
            check("reset_retire", retire, 1'b0);
            check("reset_mem_we", mem_we, 1'b0);
        end
        rst = 1'b0;
    endtask

    task automatic run_prog(input int budget, input bit exp_halt, input int stall);
        logic prev;
        prev        = 1'b0;
        hcyc        = -1;
        nret        = 0;
        we_cnt      = 0;
        pc_at_stall = 8'hAA;
        ret_cyc.delete();
        pc_after.delete();
        for (int c = 0; c < budget; c++) begin
            run = (c >= stall);
            if (c == stall) pc_at_stall = pc_out;
            if (prev) pc_after.push_back(pc_out);
            if (halted) begin
                hcyc = c;
                break;
            end
            if (retire) begin
                nret++;
                ret_cyc.push_back(c);
            end
            prev = retire;
            if (mem_we) begin
                we_cnt++;
                we_addr = mem_addr;
                we_data = mem_wdata;
            end
            @(negedge clk);
        end
        run = 1'b1;
        if (exp_halt && hcyc < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL halt_timeout: no halt within %0d cycles", budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bit   seen;

        // ---------------- ALU vector table ----------------
        vecs[0] = '{3'd0, 8'h05, 8'h03, 8'h08, 1'b0};
        vecs[1] = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{3'd0, 8'h80, 8'h80, 8'h00, 1'b1};
        vecs[3] = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[4] = '{3'd1, 8'h02, 8'h03, 8'hFF, 1'b1};
        vecs[5] = '{3'd1, 8'h03, 8'h03, 8'h00, 1'b0};
        vecs[6] = '{3'd1, 8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[7] = '{3'd1, 8'h10, 8'h01, 8'h0F, 1'b0};
        vecs[8] = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[9] = '{3'd2, 8'hAA, 8'h55, 8'h00, 1'b0};

        // ---- Test 1: LI 5; MOV r1; LI 3; ADD r1; HALT ----
        begin_test();
        pw(0, 8'h65); pw(1, 8'h81); pw(2, 8'h63); pw(3, 8'h01); pw(4, 8'hFF);
        load_prog();
        reset_core(1);
        run_prog(40, 1, 0);
        check("t1_halt_cycle", hcyc, 15);
        check("t1_retires", nret, 5);
        check("t1_first_retire_cycle", (ret_cyc.size() > 0) ? ret_cyc[0] : -1, 2);
        check("t1_acc", acc_out, 8'h08);
        check("t1_carry", carry, 1'b0);

        // ---- Test 2: SUB borrow then ADD of 0xFF + 0xFF ----
        begin_test();
        pw(0, 8'h63); pw(1, 8'h81); pw(2, 8'h62); pw(3, 8'h21);
        pw(4, 8'h7F); pw(5, 8'h82); pw(6, 8'h02); pw(7, 8'hFF);
        load_prog();
        reset_core(0);
        run_prog(40, 1, 0);
        check("t2_acc", acc_out, 8'hFE);
        check("t2_carry", carry, 1'b1);

        // ---- Test 2b: reset clears the register file ----
        begin_test();
        pw(0, 8'h60); pw(1, 8'h01); pw(2, 8'h02); pw(3, 8'hFF);
        load_prog();
        reset_core(0);
        run_prog(40, 1, 0);
        check("t2b_acc_regs_cleared", acc_out, 8'h00);

        // ---- Test 3: SW then LW round trip ----
        begin_test();
        pw(0, 8'h6A); pw(1, 8'h82); pw(2, 8'h6C); pw(3, 8'hC2);
        pw(4, 8'hA3); pw(5, 8'h60); pw(6, 8'h03); pw(7, 8'hFF);
        load_prog();
        reset_core(0);
        run_prog(60, 1, 0);
        check("t3_we_cycles", we_cnt, 1);
        check("t3_we_addr", we_addr, 8'h0C);
        check("t3_we_data", we_data, 8'h0A);
        check("t3_mem_stored", mem[12], 8'h0A);
        check("t3_lw_latency", (ret_cyc.size() > 4) ? (ret_cyc[4] - ret_cyc[3]) : -1, 4);
        check("t3_acc", acc_out, 8'h0A);

        // ---- Test 4: BRZ countdown loop ----
        begin_test();
        pw(0, 8'h61);  pw(1, 8'h81);  pw(2, 8'h6F);  pw(3, 8'h82);
        pw(4, 8'h68);  pw(5, 8'h83);  pw(6, 8'h62);  pw(7, 8'h80);
        pw(8, 8'h60);  pw(9, 8'h00);  pw(10, 8'h21); pw(11, 8'h80);
        pw(12, 8'hE2); pw(13, 8'h60); pw(14, 8'hE3); pw(15, 8'hFF);
        load_prog();
        reset_core(0);
        run_prog(120, 1, 0);
        check("t4_retires", nret, 21);
        check("t4_brz_not_taken_pc", (pc_after.size() > 12) ? pc_after[12] : 8'hEE, 8'h0D);
        check("t4_brz_loop_pc", (pc_after.size() > 14) ? pc_after[14] : 8'hEE, 8'h08);
        check("t4_brz_exit_pc", (pc_after.size() > 19) ? pc_after[19] : 8'hEE, 8'h0F);
        check("t4_acc", acc_out, 8'h00);

        // ---- Test 5: reset during SW EXEC suppresses the store ----
        begin_test();
        pw(0, 8'h6A); pw(1, 8'h82); pw(2, 8'h6C); pw(3, 8'hC2); pw(4, 8'hFF);
        load_prog();
        poke(8'h0C, 8'h55);
        reset_core(0);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (mem_we) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL t5_sw_timeout: no store strobe within 30 cycles");
        end
        check("t5_sw_addr", mem_addr, 8'h0C);
        rst = 1'b1;
        #1;
        check("t5_we_masked", mem_we, 1'b0);
        @(negedge clk);
        check("t5_mem_unchanged", mem[12], 8'h55);
        check("t5_pc", pc_out, 8'h00);
        check("t5_acc", acc_out, 8'h00);
        check("t5_fetch_addr", mem_addr, 8'h00);

        // ---- Test 6: run=0 stall, then pc wrap 0xFF -> 0x00 ----
        begin_test();
        pw(0, 8'h7F); pw(1, 8'h81); pw(2, 8'h60); pw(3, 8'hE1);
        load_prog();
        poke(8'hFF, 8'h65);
        reset_core(0);
        run_prog(22, 0, 5);
        check("t6_stall_pc", pc_at_stall, 8'h00);
        check("t6_first_retire_cycle", (ret_cyc.size() > 0) ? ret_cyc[0] : -1, 7);
        check("t6_pc_after_count", pc_after.size(), 5);
        check("t6_brz_to_ff", (pc_after.size() > 3) ? pc_after[3] : 8'hEE, 8'hFF);
        check("t6_pc_wrap", (pc_after.size() > 4) ? pc_after[4] : 8'hEE, 8'h00);
        check("t6_acc", acc_out, 8'h05);

        // ---- Test 7: table-driven ALU vectors via scoreboard ----
        for (int i = 0; i < 10; i++) begin
            begin_test();
            pw(0, 8'h70); pw(1, 8'hA0); pw(2, 8'h71); pw(3, 8'hA1);
            pw(4, 8'h60); pw(5, 8'h00); pw(6, {vecs[i].op, 5'd1}); pw(7, 8'hFF);
            load_prog();
            poke(8'hF0, vecs[i].a);
            poke(8'hF1, vecs[i].b);
            exp_q.push_back('{vecs[i].exp_acc, vecs[i].exp_c});
            reset_core(0);
            run_prog(60, 1, 0);
            if (halted) begin
                e = exp_q.pop_front();
                check($sformatf("vec%0d_acc", i), acc_out, e.acc);
                check($sformatf("vec%0d_carry", i), carry, e.c);
                check($sformatf("vec%0d_retires", i), nret, 8);
            end else begin
                void'(exp_q.pop_front());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
